// File: rtl/ula_kb_pkg.sv
// Shared constants and helpers for the keyboard / general-purpose pad bank.
// The optional glitch filter is selected with the ULA_KB_FILTER_EN macro.
package ula_kb_pkg;

    // Level of an idle (released, pulled-up) pin; every register resets to it.
    localparam logic KB_IDLE_LEVEL = 1'b1;

    // Default geometry: KB0..KB4 with a 12-cycle stability window.
    localparam int KB_DEFAULT_CHANNELS   = 5;
    localparam int KB_DEFAULT_FILTER_LEN = 12;

    // Smallest counter width that can hold every value 0..filter_len,
    // i.e. the smallest w with 2**w > filter_len.
    function automatic int kb_min_cnt_w(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/ula_kb_filter_ch.sv
// One pad channel: two-flop synchroniser, optional stability filter and a
// registered change strobe. With ULA_KB_FILTER_EN undefined the filter is
// replaced by a single register stage and the FILTER_LEN/CNT_W parameters
// disappear from this module.
module ula_kb_filter_ch
    import ula_kb_pkg::*;
`ifdef ULA_KB_FILTER_EN
#(
    parameter int FILTER_LEN = KB_DEFAULT_FILTER_LEN,
    parameter int CNT_W      = 8
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    output logic from_pad,
    output logic filt,
    output logic change
);

    logic s1;
    logic s2;

    // Bring the asynchronous pin level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= KB_IDLE_LEVEL;
            s2 <= KB_IDLE_LEVEL;
        end else begin
            s1 <= pad_in;
            s2 <= s1;
        end
    end

    assign from_pad = s2;

`ifdef ULA_KB_FILTER_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // Accept a new level only after it has differed from filt for FILTER_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            filt   <= KB_IDLE_LEVEL;
            change <= 1'b0;
        end else if (s2 == filt) begin
            cnt    <= '0;
            change <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            filt   <= s2;
            change <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_W'(1);
            change <= 1'b0;
        end
    end
`else
    // No filtering: filt is s2 delayed once, change flags the new value in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= KB_IDLE_LEVEL;
            change <= 1'b0;
        end else begin
            filt   <= s2;
            change <= s2 ^ filt;
        end
    end
`endif

endmodule

// File: rtl/ula_kb_pad_bank.sv
// Bank of CHANNELS open-drain pads with per-channel conditioning.
// Optional glitch filter selected by the ULA_KB_FILTER_EN macro; without it
// filt is the synchronised level delayed by one extra register.
module ula_kb_pad_bank
    import ula_kb_pkg::*;
#(
    parameter int CHANNELS   = KB_DEFAULT_CHANNELS,
    parameter int FILTER_LEN = KB_DEFAULT_FILTER_LEN,
    parameter int CNT_W      = 8
)
(
    input  logic                clk,
    input  logic                rst,
    inout  wire  [CHANNELS-1:0] pad,
    input  logic [CHANNELS-1:0] to_pad,
    output logic [CHANNELS-1:0] from_pad,
    output logic [CHANNELS-1:0] filt,
    output logic [CHANNELS-1:0] change,
    output logic                any_low
);

    // Reject parameter combinations the channel logic cannot represent.
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("ula_kb_pad_bank: CHANNELS=%0d outside 1..16", CHANNELS);
    end
    if (FILTER_LEN < 1 || CNT_W < kb_min_cnt_w(FILTER_LEN)) begin : g_bad_cnt_w
        $error("ula_kb_pad_bank: CNT_W=%0d too small for FILTER_LEN=%0d", CNT_W, FILTER_LEN);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Open-drain drive: pull low on 0, release to the external pull-up on 1.
        assign pad[i] = to_pad[i] ? 1'bz : 1'b0;

`ifdef ULA_KB_FILTER_EN
        ula_kb_filter_ch #(
            .FILTER_LEN (FILTER_LEN),
            .CNT_W      (CNT_W)
        ) u_ch (
`else
        ula_kb_filter_ch u_ch (
`endif
            .clk      (clk),
            .rst      (rst),
            .pad_in   (pad[i]),
            .from_pad (from_pad[i]),
            .filt     (filt[i]),
            .change   (change[i])
        );
    end

    assign any_low = ~(&filt);

endmodule
